dma_priority_arbiter: RTL and testbench

- Channel arbiter and hold-handshake sequencer for the 8237A-style DMA controller.
- Samples the per-channel Dreq lines from the IO devices and applies Mask plus fixed or rotating priority.
- Requests the bus from the CPU (Hrq/Hlda), then grants exactly one channel via a one-hot Dack for one service.
- Tells the timing/transfer unit which channel is active. Sits between the IO device Dreq/Dack pins and the transfer timing FSM.

---
 rtl/dma_arb_pkg.sv | 18 +
 rtl/dma_priority_encoder.sv | 36 +++
 rtl/dma_priority_arbiter.sv | 136 +++++++++++++
 tb/tb_dma_priority_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA channel arbiter.
package dma_arb_pkg;

    localparam int unsigned NUM_CH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_REQ = 2'd1,
        ACTIVE   = 2'd2,
        RELEASE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PRI_FIXED  = 1'b0,
        PRI_ROTATE = 1'b1
    } pri_mode_t;

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational priority resolver: picks one requesting channel, either
// lowest-index-first or searching upward from a start index with wrap.
module dma_priority_encoder
    import dma_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEFAULT
) (
    input  logic [NUM_CH-1:0]         i_req,
    input  logic [$clog2(NUM_CH)-1:0] i_start,
    input  pri_mode_t                 i_mode,
    output logic [$clog2(NUM_CH)-1:0] o_winner,
    output logic                      o_valid
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0] w_start;
    int unsigned     w_idx;

    // Scan from farthest to nearest offset so the nearest requester is the
    // last assignment and therefore wins.
    always_comb begin
        w_start  = (i_mode == PRI_ROTATE) ? i_start : '0;
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        for (int unsigned k = NUM_CH; k > 0; k--) begin
            w_idx = (32'(w_start) + k - 1) % NUM_CH;
            if (i_req[w_idx]) begin
                o_winner = CH_W'(w_idx);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: masks requests, negotiates the bus with the CPU via
// Hrq/Hlda and grants one channel per service with a one-hot Dack.
module dma_priority_arbiter
    import dma_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEFAULT
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_CH-1:0]         Dreq,
    input  logic [NUM_CH-1:0]         Mask,
    input  logic                      RotatePri,
    input  logic                      CtrlDisable,
    input  logic                      Hlda,
    input  logic                      TransferDone,
    output logic                      Hrq,
    output logic [NUM_CH-1:0]         Dack,
    output logic [$clog2(NUM_CH)-1:0] ActiveCh,
    output logic                      Busy,
    output logic                      ServiceStart
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    arb_state_t        r_state;
    logic              r_hrq;
    logic [NUM_CH-1:0] r_dack;
    logic [CH_W-1:0]   r_active_ch;
    logic              r_busy;
    logic              r_svc_start;
    logic [CH_W-1:0]   r_last;

    logic [NUM_CH-1:0] w_eff_req;
    logic              w_any_req;
    logic [CH_W-1:0]   w_start;
    pri_mode_t         w_mode;
    logic [CH_W-1:0]   w_winner;
    logic              w_valid;
    logic [NUM_CH-1:0] w_grant;

    assign w_eff_req = Dreq & ~Mask;
    assign w_any_req = |w_eff_req;
    assign w_mode    = RotatePri ? PRI_ROTATE : PRI_FIXED;

    // Rotating search begins one past the last serviced channel, wrapping.
    always_comb begin
        if (r_last == CH_W'(NUM_CH - 1))
            w_start = '0;
        else
            w_start = r_last + 1'b1;
    end

    dma_priority_encoder #(
        .NUM_CH (NUM_CH)
    ) u_enc (
        .i_req    (w_eff_req),
        .i_start  (w_start),
        .i_mode   (w_mode),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // One-hot decode of the resolved winner.
    always_comb begin
        w_grant           = '0;
        w_grant[w_winner] = 1'b1;
    end

    // Arbitration FSM with registered outputs and the rotation pointer.
    // RELEASE supplies the single mandatory Hrq-low cycle; it then behaves
    // like IDLE so a pending request re-raises Hrq without a second gap.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_hrq       <= 1'b0;
            r_dack      <= '0;
            r_active_ch <= '0;
            r_busy      <= 1'b0;
            r_svc_start <= 1'b0;
            r_last      <= CH_W'(NUM_CH - 1);
        end else begin
            r_svc_start <= 1'b0;
            case (r_state)
                IDLE, RELEASE: begin
                    if (!CtrlDisable && w_any_req) begin
                        r_state <= HOLD_REQ;
                        r_hrq   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_hrq   <= 1'b0;
                    end
                end
                HOLD_REQ: begin
                    if (Hlda) begin
                        if (w_valid) begin
                            r_state     <= ACTIVE;
                            r_dack      <= w_grant;
                            r_active_ch <= w_winner;
                            r_busy      <= 1'b1;
                            r_svc_start <= 1'b1;
                        end else begin
                            r_state <= RELEASE;
                            r_hrq   <= 1'b0;
                        end
                    end else if (!w_any_req) begin
                        r_state <= IDLE;
                        r_hrq   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (TransferDone || !Hlda) begin
                        r_state <= RELEASE;
                        r_hrq   <= 1'b0;
                        r_dack  <= '0;
                        r_busy  <= 1'b0;
                        if (TransferDone && RotatePri)
                            r_last <= r_active_ch;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_hrq   <= 1'b0;
                    r_dack  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Hrq          = r_hrq;
    assign Dack         = r_dack;
    assign ActiveCh     = r_active_ch;
    assign Busy         = r_busy;
    assign ServiceStart = r_svc_start;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with a grant scoreboard.
module tb_dma_priority_arbiter;

    localparam int unsigned NCH = 4;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [NCH-1:0] Dreq;
    logic [NCH-1:0] Mask;
    logic           RotatePri;
    logic           CtrlDisable;
    logic           Hlda;
    logic           TransferDone;
    logic           Hrq;
    logic [NCH-1:0] Dack;
    logic [1:0]     ActiveCh;
    logic           Busy;
    logic           ServiceStart;

    typedef struct {
        string      tag;
        logic [1:0] ch;
    } grant_t;

    grant_t sb[$];
    int     n_assert = 0;
    int     n_fail   = 0;

    dma_priority_arbiter #(.NUM_CH(NCH)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Dreq         (Dreq),
        .Mask         (Mask),
        .RotatePri    (RotatePri),
        .CtrlDisable  (CtrlDisable),
        .Hlda         (Hlda),
        .TransferDone (TransferDone),
        .Hrq          (Hrq),
        .Dack         (Dack),
        .ActiveCh     (ActiveCh),
        .Busy         (Busy),
        .ServiceStart (ServiceStart)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check the Dack invariant away from the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
        chk("dack_onehot0", 32'($onehot0(Dack)), 32'd1);
        chk("dack_needs_hrq", 32'((Dack == '0) || Hrq), 32'd1);
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] ch);
        grant_t g;
        g.tag = tag;
        g.ch  = ch;
        sb.push_back(g);
    endtask

    // Waits (bounded) for ServiceStart and compares against the oldest entry.
    task automatic check_grant();
        grant_t g;
        int     waited;
        logic [NCH-1:0] exp_dack;
        waited = 0;
        tick();
        while (!ServiceStart && waited < 4) begin
            tick();
            waited++;
        end
        chk("grant_latency", 32'(waited), 32'd0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            exp_dack = '0;
            exp_dack[g.ch] = 1'b1;
            chk({g.tag, "_start"}, 32'(ServiceStart), 32'd1);
            chk({g.tag, "_dack"},  32'(Dack),         32'(exp_dack));
            chk({g.tag, "_ch"},    32'(ActiveCh),     32'(g.ch));
            chk({g.tag, "_busy"},  32'(Busy),         32'd1);
            chk({g.tag, "_hrq"},   32'(Hrq),          32'd1);
        end
    endtask

    initial begin
        Reset = 1'b1; Dreq = '0; Mask = '0; RotatePri = 1'b0;
        CtrlDisable = 1'b0; Hlda = 1'b0; TransferDone = 1'b0;
        tick(); tick();
        chk("rst_hrq",   32'(Hrq),          32'd0);
        chk("rst_dack",  32'(Dack),         32'd0);
        chk("rst_ch",    32'(ActiveCh),     32'd0);
        chk("rst_busy",  32'(Busy),         32'd0);
        chk("rst_start", 32'(ServiceStart), 32'd0);
        Reset = 1'b0;
        tick();

        // Fixed priority, Hlda three cycles after Hrq.
        Dreq = 4'b1010;
        tick();
        chk("fix_hrq_rise", 32'(Hrq), 32'd1);
        tick(); tick();
        chk("fix_hrq_hold", 32'(Hrq), 32'd1);
        Hlda = 1'b1;
        expect_grant("fix", 2'd1);
        check_grant();
        tick();
        chk("fix_start_pulse", 32'(ServiceStart), 32'd0);
        chk("fix_dack_hold",   32'(Dack),         32'b0010);
        Dreq = 4'b0000;
        TransferDone = 1'b1;
        tick();
        TransferDone = 1'b0;
        chk("fix_done_dack", 32'(Dack), 32'd0);
        chk("fix_done_busy", 32'(Busy), 32'd0);
        chk("fix_done_hrq",  32'(Hrq),  32'd0);
        Hlda = 1'b0;
        tick();
        chk("fix_idle_hrq", 32'(Hrq), 32'd0);

        // Rotating priority, all channels requesting, five services.
        RotatePri = 1'b1;
        Dreq = 4'b1111;
        tick();
        chk("rot_hrq_rise", 32'(Hrq), 32'd1);
        for (int unsigned i = 0; i < 5; i++) begin
            Hlda = 1'b1;
            expect_grant($sformatf("rot%0d", i), 2'(i % 4));
            check_grant();
            TransferDone = 1'b1;
            tick();
            TransferDone = 1'b0;
            Hlda = 1'b0;
            chk("rot_gap_hrq", 32'(Hrq), 32'd0);
            if (i == 4) Dreq = 4'b0000;
            tick();
            chk("rot_gap_end", 32'(Hrq), (i < 4) ? 32'd1 : 32'd0);
        end

        // Hlda in IDLE is ignored; masked request never raises Hrq.
        Hlda = 1'b1;
        tick();
        chk("idle_hlda_hrq", 32'(Hrq), 32'd0);
        Hlda = 1'b0;
        Dreq = 4'b0001; Mask = 4'b0001;
        tick(); tick();
        chk("mask_hrq", 32'(Hrq), 32'd0);
        Mask = 4'b0000;
        Dreq = 4'b0100;
        tick();
        chk("wd_hrq_rise", 32'(Hrq), 32'd1);
        Dreq = 4'b0000;
        tick();
        chk("wd_hrq_drop", 32'(Hrq),  32'd0);
        chk("wd_dack",     32'(Dack), 32'd0);
        tick();
        chk("wd_idle", 32'(Hrq), 32'd0);

        // Reset while ch3 is being serviced.
        Dreq = 4'b1000;
        tick();
        Hlda = 1'b1;
        expect_grant("pre_rst", 2'd3);
        check_grant();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mrst_hrq",  32'(Hrq),  32'd0);
        chk("mrst_dack", 32'(Dack), 32'd0);
        chk("mrst_busy", 32'(Busy), 32'd0);
        chk("mrst_ch",   32'(ActiveCh), 32'd0);
        Hlda = 1'b0;
        Dreq = 4'b1001;
        tick();
        chk("post_rst_hrq", 32'(Hrq), 32'd1);
        Hlda = 1'b1;
        expect_grant("post_rst", 2'd0);
        check_grant();
        TransferDone = 1'b1;
        tick();
        TransferDone = 1'b0;
        Hlda = 1'b0;
        Dreq = 4'b0000;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;

        // CPU abort on ch2 leaves the rotation pointer untouched.
        Dreq = 4'b0100;
        tick();
        Hlda = 1'b1;
        expect_grant("abort", 2'd2);
        check_grant();
        tick();
        Hlda = 1'b0;
        tick();
        chk("abort_dack", 32'(Dack), 32'd0);
        chk("abort_hrq",  32'(Hrq),  32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        Dreq = 4'b1111;
        tick();
        chk("abort_rereq", 32'(Hrq), 32'd1);
        Hlda = 1'b1;
        expect_grant("after_abort", 2'd0);
        check_grant();
        TransferDone = 1'b1;
        tick();
        TransferDone = 1'b0;
        Hlda = 1'b0;
        Dreq = 4'b0000;
        tick();

        // CtrlDisable during ch1 service; stray TransferDone in HOLD_REQ.
        RotatePri = 1'b0;
        Dreq = 4'b0010;
        tick();
        TransferDone = 1'b1;
        tick();
        TransferDone = 1'b0;
        chk("stray_done_hrq",  32'(Hrq),  32'd1);
        chk("stray_done_dack", 32'(Dack), 32'd0);
        Hlda = 1'b1;
        expect_grant("dis", 2'd1);
        check_grant();
        CtrlDisable = 1'b1;
        Dreq = 4'b0001;
        tick();
        chk("dis_dack_hold", 32'(Dack), 32'b0010);
        TransferDone = 1'b1;
        tick();
        TransferDone = 1'b0;
        Hlda = 1'b0;
        chk("dis_done_dack", 32'(Dack), 32'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("dis_no_hrq", 32'(Hrq), 32'd0);
        end
        CtrlDisable = 1'b0;
        tick();
        chk("en_hrq", 32'(Hrq), 32'd1);
        Hlda = 1'b1;
        expect_grant("en", 2'd0);
        check_grant();
        TransferDone = 1'b1;
        tick();
        TransferDone = 1'b0;
        Hlda = 1'b0;
        Dreq = 4'b0000;
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
